// File: rtl/common.sv
// Shared definitions for the sequenced ALU: opcodes understood by the external
// 32-bit ALU, the sequencer state encoding, and a small opcode helper.
package common;

    localparam logic [2:0] ALU_NOP0 = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_XOR  = 3'd5;
    localparam logic [2:0] ALU_NOP6 = 3'd6;
    localparam logic [2:0] ALU_NOP7 = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } alu_seq_state_e;

    // Only the arithmetic opcodes chain the low-pass carry into the high pass.
    function automatic logic carry_chains(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-requester round-robin arbiter; the pointer names the requester that
// wins a tie and moves past the winner only when a grant is taken.
module alu_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_r;

    // Pointer holder first, then the other requester.
    always_comb begin
        grant = 2'b00;
        if (req[ptr_r]) begin
            grant[ptr_r] = 1'b1;
        end else if (req[~ptr_r]) begin
            grant[~ptr_r] = 1'b1;
        end else begin
            grant = 2'b00;
        end
    end

    // After an accept the requester that was not served gets priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (advance) begin
            ptr_r <= grant[0];
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequencer that time-shares one external 32-bit ALU between two requesters,
// running 64-bit operations as a low pass followed by a carry-chained high pass.
module alu_seq
    import common::*;
#(
    parameter bit WIDE_EN = 1'b1
) (
    input  logic          CLK,
    input  logic          N_RST,
    input  logic [1:0]    REQ_VALID,
    output logic [1:0]    REQ_READY,
    input  logic [5:0]    REQ_OP,
    input  logic [127:0]  REQ_A,
    input  logic [127:0]  REQ_B,
    input  logic [1:0]    REQ_WIDE,
    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic          RSP_ID,
    output logic [63:0]   RSP_OUT,
    output logic          RSP_Z,
    output logic          RSP_C,
    output logic          RSP_N,
    output logic [31:0]   ALU_A,
    output logic [31:0]   ALU_B,
    output logic [2:0]    ALU_OP,
    output logic          ALU_C_IN,
    input  logic [31:0]   ALU_OUT,
    input  logic          ALU_Z,
    input  logic          ALU_C,
    input  logic          ALU_N
);

    alu_seq_state_e state_r;
    logic [1:0]     grant_s;
    logic           accept_s;
    logic           sel_s;
    logic           wide_s;
    logic [2:0]     op_s;
    logic [63:0]    a_s;
    logic [63:0]    b_s;
    logic [2:0]     op_r;
    logic           wide_r;
    logic [31:0]    a_hi_r;
    logic [31:0]    b_hi_r;
    logic [31:0]    lo_out_r;
    logic           lo_z_r;

    alu_rr_arb u_arb (
        .clk     (CLK),
        .rst_n   (N_RST),
        .req     (REQ_VALID),
        .advance (accept_s),
        .grant   (grant_s)
    );

    // Grant is offered only while idle and out of reset.
    always_comb begin
        if ((state_r == IDLE) && N_RST) begin
            REQ_READY = grant_s;
        end else begin
            REQ_READY = 2'b00;
        end
    end

    // Select the winning requester's fields.
    always_comb begin
        accept_s = |(REQ_VALID & REQ_READY);
        sel_s    = REQ_READY[1];
        if (sel_s) begin
            op_s   = REQ_OP[5:3];
            a_s    = REQ_A[127:64];
            b_s    = REQ_B[127:64];
            wide_s = REQ_WIDE[1] & WIDE_EN;
        end else begin
            op_s   = REQ_OP[2:0];
            a_s    = REQ_A[63:0];
            b_s    = REQ_B[63:0];
            wide_s = REQ_WIDE[0] & WIDE_EN;
        end
    end

    // Sequencer FSM; ALU drive and response are registered so each pass sees stable operands.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state_r   <= IDLE;
            op_r      <= ALU_NOP0;
            wide_r    <= 1'b0;
            a_hi_r    <= 32'h0;
            b_hi_r    <= 32'h0;
            lo_out_r  <= 32'h0;
            lo_z_r    <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_ID    <= 1'b0;
            RSP_OUT   <= 64'h0;
            RSP_Z     <= 1'b0;
            RSP_C     <= 1'b0;
            RSP_N     <= 1'b0;
            ALU_A     <= 32'h0;
            ALU_B     <= 32'h0;
            ALU_OP    <= ALU_NOP0;
            ALU_C_IN  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r  <= LO;
                        op_r     <= op_s;
                        wide_r   <= wide_s;
                        a_hi_r   <= a_s[63:32];
                        b_hi_r   <= b_s[63:32];
                        RSP_ID   <= sel_s;
                        ALU_A    <= a_s[31:0];
                        ALU_B    <= b_s[31:0];
                        ALU_OP   <= op_s;
                        ALU_C_IN <= (op_s == ALU_SUB);
                    end
                end
                LO: begin
                    lo_out_r <= ALU_OUT;
                    lo_z_r   <= ALU_Z;
                    if (wide_r) begin
                        state_r  <= HI;
                        ALU_A    <= a_hi_r;
                        ALU_B    <= b_hi_r;
                        ALU_C_IN <= carry_chains(op_r) & ALU_C;
                    end else begin
                        state_r   <= RESP;
                        RSP_VALID <= 1'b1;
                        RSP_OUT   <= {32'h0, ALU_OUT};
                        RSP_Z     <= ALU_Z;
                        RSP_C     <= ALU_C;
                        RSP_N     <= ALU_N;
                        ALU_A     <= 32'h0;
                        ALU_B     <= 32'h0;
                        ALU_OP    <= ALU_NOP0;
                        ALU_C_IN  <= 1'b0;
                    end
                end
                HI: begin
                    state_r   <= RESP;
                    RSP_VALID <= 1'b1;
                    RSP_OUT   <= {ALU_OUT, lo_out_r};
                    RSP_Z     <= lo_z_r & ALU_Z;
                    RSP_C     <= ALU_C;
                    RSP_N     <= ALU_N;
                    ALU_A     <= 32'h0;
                    ALU_B     <= 32'h0;
                    ALU_OP    <= ALU_NOP0;
                    ALU_C_IN  <= 1'b0;
                end
                RESP: begin
                    if (RSP_READY) begin
                        state_r   <= IDLE;
                        RSP_VALID <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    RSP_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule
